bram_burst_arbiter: RTL and testbench
=====================================

Name: bram_burst_arbiter

Overview:
- Parametrised N-requester arbiter in front of the user-area BRAM controller.
- Generalises the current cache-miss/DMA arbitration to NUM_REQ masters, with selectable fixed-priority or round-robin policy.
- Supports multi-beat read and write bursts, and tracks outstanding reads so that read data is routed back to the owning requester.
- Sits between the instruction cache / DMA channels and bram_controller; all traffic runs on the Wishbone clock domain.

Parameters:
- NUM_REQ, 3, number of requesting masters (2..8).
- ADDR_W, 13, BRAM word-address width.
- DATA_W, 32, data width.
- LEN_W, 4, burst-length field width; burst = len+1 beats, max 2^LEN_W.
- MAX_OUTST, 4, maximum issued-but-unreturned read beats (power of 2).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- mode_i  in  1  0 = fixed priority (index 0 highest); 1 = round-robin. Sampled only in IDLE.
- req_valid_i  in  NUM_REQ  request / write-beat valid per master.
- req_we_i  in  NUM_REQ  1 = write burst.
- req_addr_i  in  NUM_REQ*ADDR_W  burst base address.
- req_len_i  in  NUM_REQ*LEN_W  beats-1.
- req_wdata_i  in  NUM_REQ*DATA_W  write data for the current beat.
- req_ready_o  out  NUM_REQ  read: one-cycle command accept; write: per-beat accept.
- rsp_valid_o  out  NUM_REQ  read data valid, asserted only for the owner.
- rsp_data_o  out  DATA_W  read data (shared bus).
- rsp_last_o  out  1  final read beat.
- grant_o  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy_o  out  1  a transaction is in progress.
- bram_valid_o  out  1  command valid to BRAM controller.
- bram_we_o  out  1  write enable.
- bram_addr_o  out  ADDR_W  beat address.
- bram_wdata_o  out  DATA_W  write data.
- bram_ready_i  in  1  BRAM accepts a command this cycle.
- bram_rvalid_i  in  1  read data returned (in-order, any latency ≥ 1).
- bram_rdata_i  in  DATA_W  read data.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, RR pointer = 0, all counters 0.
- Reset takes effect mid-burst; an in-flight bram_rvalid_i arriving after reset is ignored.

FSM states: IDLE, XFER, DRAIN.

IDLE:
- If any req_valid_i is set, choose a winner. Fixed mode: lowest index. RR mode: first valid index at or after the pointer, cyclically.
- Register the winner in grant_o, and latch we, base address and len. Go to XFER the next cycle.
- A read winner gets a req_ready_o pulse in this same cycle.
- Requests asserted in the same cycle are resolved by the policy only; losers keep req_valid_i asserted (no drop).

XFER:
- bram_valid_o = 1; bram_addr_o = (base + beat_cnt) mod 2^ADDR_W, so addresses wrap.
- A beat is issued when bram_valid_o && bram_ready_i.
- Write beats: bram_valid_o = req_valid_i[g]; bram_wdata_o = req_wdata_i[g]; req_ready_o[g] = bram_ready_i.
- Read beats: bram_valid_o is deasserted while outst_cnt == MAX_OUTST. An issue and a return in the same cycle leave outst_cnt unchanged.
- On the last beat issued: a write goes to IDLE (release); a read goes to DRAIN.

Read data path (XFER and DRAIN):
- bram_rvalid_i drives rsp_valid_o[g] and rsp_data_o combinationally, with zero added latency.
- rsp_last_o is asserted when ret_cnt == len.
- DRAIN exits to IDLE after the last return.
- bram_rvalid_i in IDLE is ignored.

Grant release:
- On release, grant_o goes to 0 and busy_o to 0.
- In RR mode the pointer is set to (owner+1) mod NUM_REQ; in fixed mode the pointer is unchanged.
- There is one idle cycle between transactions, so minimum turnaround = 1 cycle.

Other rules:
- addr, len and we are ignored after latch; changing them mid-burst has no effect.
- busy_o = (state != IDLE).
- The grant is never preempted: a higher-priority request waits for the burst to finish.

Test Plan:
- Fixed priority: mode=0; req0 and req2 both read at cycle 0 with len 0 → grant 001 first, req2 granted 3+ cycles later; rsp_valid only on the owner's bit.
- Round-robin: mode=1; all 3 masters request continuously with single-beat writes → grant order 0,1,2,0,1,2 with one idle cycle between grants; no master waits more than 2 grants.
- Read burst with backpressure: req1 reads addr 0x0040, len 3; bram_ready_i low on alternate cycles; read latency 2 → addresses 0x40..0x43 issued once each; 4 rsp beats; rsp_last_o on the 4th only; outst_cnt never exceeds MAX_OUTST.
- Write burst with requester stall: req0 writes len 2 at 0x0100 and drops req_valid_i for 2 cycles mid-burst → exactly 3 BRAM writes to 0x100, 0x101, 0x102 with matching data.
- Address wrap: read at 0x1FFE, len 3 → bram_addr_o sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Reset mid-burst: assert wb_rst_i during the 2nd beat of a len-7 read → next cycle grant_o=0, busy_o=0, bram_valid_o=0; late bram_rvalid_i produces no rsp_valid_o.

Source files
------------

// File: rtl/bram_burst_arbiter.sv
// N-master burst arbiter in front of the BRAM controller: fixed-priority or round-robin
// grant, multi-beat read/write bursts, bounded outstanding reads routed back to the owner.
`timescale 1ns/1ps
module bram_burst_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        mode_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic                        rsp_last_o,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        busy_o,
  output logic                        bram_valid_o,
  output logic                        bram_we_o,
  output logic [ADDR_W-1:0]           bram_addr_o,
  output logic [DATA_W-1:0]           bram_wdata_o,
  input  logic                        bram_ready_i,
  input  logic                        bram_rvalid_i,
  input  logic [DATA_W-1:0]           bram_rdata_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q;
  logic [PTR_W-1:0]    owner_q, rr_ptr_q, win_idx;
  logic                we_q, mode_q, win_found;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q, beat_cnt_q, ret_cnt_q;
  logic [OUT_W-1:0]    outst_cnt_q;
  logic                issue, rd_issue, rsp_any, last_issue, last_ret, release_grant;

  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [LEN_W-1:0]    len_a   [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr_i[i*ADDR_W +: ADDR_W];
    assign len_a[i]   = req_len_i[i*LEN_W +: LEN_W];
    assign wdata_a[i] = req_wdata_i[i*DATA_W +: DATA_W];
  end

  // Round-robin scans cyclically from the pointer; fixed mode scans from index 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = mode_i ? (int'(rr_ptr_q) + i) % NUM_REQ : i;
      if (!win_found && req_valid_i[j]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(j);
      end
    end
  end

  assign issue         = (state_q == XFER) && bram_valid_o && bram_ready_i;
  assign rd_issue      = issue && !we_q;
  assign rsp_any       = |rsp_valid_o;
  assign last_issue    = issue && (beat_cnt_q == len_q);
  assign last_ret      = rsp_any && (ret_cnt_q == len_q);
  assign release_grant = ((state_q == XFER) && last_issue && we_q) ||
                         ((state_q == DRAIN) && last_ret);

  // ---- state register ----
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = XFER;
      XFER:    if (last_issue) state_d = we_q ? IDLE : DRAIN;
      DRAIN:   if (last_ret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    rsp_data_o   = '0;
    rsp_last_o   = 1'b0;
    bram_valid_o = 1'b0;
    bram_we_o    = 1'b0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (win_found && !req_we_i[win_idx]) req_ready_o[win_idx] = 1'b1;
      end
      XFER: begin
        bram_addr_o = base_q + ADDR_W'(beat_cnt_q);
        bram_we_o   = we_q;
        if (we_q) begin
          bram_valid_o         = req_valid_i[owner_q];
          bram_wdata_o         = wdata_a[owner_q];
          req_ready_o[owner_q] = bram_ready_i;
        end else begin
          bram_valid_o = (outst_cnt_q != OUT_W'(MAX_OUTST));
        end
      end
      default: ;
    endcase
    // Read returns are forwarded with no added latency, only to the owner.
    if (state_q != IDLE && !we_q && bram_rvalid_i) begin
      rsp_valid_o[owner_q] = 1'b1;
      rsp_data_o           = bram_rdata_i;
      rsp_last_o           = (ret_cnt_q == len_q);
    end
  end

  // ---- transaction bookkeeping ----
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      grant_q     <= '0;
      owner_q     <= '0;
      we_q        <= 1'b0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      ret_cnt_q   <= '0;
      outst_cnt_q <= '0;
      rr_ptr_q    <= '0;
    end else if (state_q == IDLE) begin
      if (win_found) begin
        grant_q     <= NUM_REQ'(1) << win_idx;
        owner_q     <= win_idx;
        we_q        <= req_we_i[win_idx];
        mode_q      <= mode_i;
        len_q       <= len_a[win_idx];
        beat_cnt_q  <= '0;
        ret_cnt_q   <= '0;
        outst_cnt_q <= '0;
      end
    end else begin
      if (issue)   beat_cnt_q <= beat_cnt_q + 1'b1;
      if (rsp_any) ret_cnt_q  <= ret_cnt_q + 1'b1;
      if (rd_issue && !rsp_any)      outst_cnt_q <= outst_cnt_q + 1'b1;
      else if (!rd_issue && rsp_any) outst_cnt_q <= outst_cnt_q - 1'b1;
      if (release_grant) begin
        grant_q <= '0;
        if (mode_q)
          rr_ptr_q <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

  // Base address only steers the datapath, so it carries no reset.
  always_ff @(posedge wb_clk_i) begin
    if (state_q == IDLE && win_found) base_q <= addr_a[win_idx];
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_bram_burst_arbiter.sv
// Directed bench for bram_burst_arbiter: priority, round-robin, read/write bursts,
// outstanding-read limit, address wrap and reset during a burst.
`timescale 1ns/1ps
module tb_bram_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [2:0]  req_valid, req_we;
  logic [38:0] req_addr;
  logic [11:0] req_len;
  logic [95:0] req_wdata;
  logic [2:0]  req_ready, rsp_valid, grant;
  logic [31:0] rsp_data, bram_wdata, bram_rdata;
  logic        rsp_last, busy, bram_valid, bram_we, bram_ready, bram_rvalid;
  logic [12:0] bram_addr;

  int vec  = 0;
  int miss = 0;

  logic [12:0] iss_addr [16];
  logic [31:0] rsp_dat  [16];
  int          rsp_last_idx, last_cnt, owner_bad;

  always #5 clk = ~clk;

  bram_burst_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .mode_i(mode),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_len_i(req_len), .req_wdata_i(req_wdata), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
    .grant_o(grant), .busy_o(busy), .bram_valid_o(bram_valid), .bram_we_o(bram_we),
    .bram_addr_o(bram_addr), .bram_wdata_o(bram_wdata), .bram_ready_i(bram_ready),
    .bram_rvalid_i(bram_rvalid), .bram_rdata_i(bram_rdata)
  );

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; req_we = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one read burst from master m against a BRAM model with fixed latency.
  task automatic run_read(input int m, input logic [12:0] base, input logic [3:0] len,
                          input int lat, input bit alt_ready,
                          output int n_iss, output int n_rsp, output int max_out,
                          output bit tmo);
    int          due [$];
    logic [12:0] pa  [$];
    logic [2:0]  own;
    bit          drop;
    n_iss = 0; n_rsp = 0; max_out = 0; tmo = 1'b0; drop = 1'b0;
    rsp_last_idx = -1; last_cnt = 0; owner_bad = 0;
    own = '0; own[m] = 1'b1;
    @(posedge clk); #1;
    req_valid[m] = 1'b1; req_we[m] = 1'b0;
    req_addr[m*13 +: 13] = base; req_len[m*4 +: 4] = len;
    for (int cyc = 0; cyc < 300 && n_rsp < int'(len) + 1; cyc++) begin
      bram_ready = alt_ready ? cyc[0] : 1'b1;
      if (due.size() > 0 && due[0] <= cyc) begin
        bram_rvalid = 1'b1;
        bram_rdata  = 32'hD000_0000 | {19'b0, pa[0]};
        void'(due.pop_front());
        void'(pa.pop_front());
      end else begin
        bram_rvalid = 1'b0;
        bram_rdata  = '0;
      end
      @(negedge clk);
      if (req_ready[m]) drop = 1'b1;
      if (bram_valid && bram_ready) begin
        if (n_iss < 16) iss_addr[n_iss] = bram_addr;
        n_iss++;
        due.push_back(cyc + lat);
        pa.push_back(bram_addr);
      end
      if (rsp_valid != 3'b000) begin
        if (rsp_valid !== own) owner_bad++;
        if (n_rsp < 16) rsp_dat[n_rsp] = rsp_data;
        if (rsp_last) begin last_cnt++; rsp_last_idx = n_rsp; end
        n_rsp++;
      end
      if (n_iss - n_rsp > max_out) max_out = n_iss - n_rsp;
      @(posedge clk); #1;
      if (drop) req_valid[m] = 1'b0;
    end
    tmo = (n_rsp < int'(len) + 1);
    req_valid[m] = 1'b0;
    bram_rvalid = 1'b0;
    bram_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
    req_wdata = '0; bram_ready = 1'b1; bram_rvalid = 1'b1; bram_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec++; if (grant !== 3'b000) begin miss++; $display("FAIL reset_grant: got %b want 000", grant); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (bram_valid !== 1'b0 || bram_we !== 1'b0 || bram_addr !== 13'h0) begin
      miss++; $display("FAIL reset_bram: got v=%b we=%b a=%h want 0", bram_valid, bram_we, bram_addr); end
    vec++; if (req_ready !== 3'b000) begin miss++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    vec++; if (rsp_valid !== 3'b000 || rsp_last !== 1'b0) begin
      miss++; $display("FAIL idle_rvalid_ignored: got rsp_valid=%b last=%b want 0", rsp_valid, rsp_last); end
    @(posedge clk); #1 bram_rvalid = 1'b0;
  endtask

  task automatic test_fixed_priority();
    mode = 1'b0; req_we = 3'b000; req_len = '0;
    req_addr[0 +: 13] = 13'h010; req_addr[26 +: 13] = 13'h020;
    req_valid = 3'b101;
    @(negedge clk);
    vec++; if (req_ready !== 3'b001 || grant !== 3'b000) begin
      miss++; $display("FAIL fixed_c0: got ready=%b grant=%b want 001/000", req_ready, grant); end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    vec++; if (grant !== 3'b001 || bram_valid !== 1'b1 || bram_addr !== 13'h010) begin
      miss++; $display("FAIL fixed_c1: got grant=%b v=%b a=%h want 001/1/010", grant, bram_valid, bram_addr); end
    @(posedge clk); #1 bram_rvalid = 1'b1; bram_rdata = 32'h1234_5678;
    @(negedge clk);
    vec++; if (rsp_valid !== 3'b001 || rsp_data !== 32'h1234_5678 || rsp_last !== 1'b1) begin
      miss++; $display("FAIL fixed_rsp0: got v=%b d=%h l=%b want 001/12345678/1", rsp_valid, rsp_data, rsp_last); end
    @(posedge clk); #1 bram_rvalid = 1'b0;
    @(negedge clk);
    vec++; if (grant !== 3'b000 || req_ready !== 3'b100) begin
      miss++; $display("FAIL fixed_c3: got grant=%b ready=%b want 000/100", grant, req_ready); end
    @(posedge clk); #1 req_valid[2] = 1'b0;
    @(negedge clk);
    vec++; if (grant !== 3'b100 || bram_addr !== 13'h020) begin
      miss++; $display("FAIL fixed_c4: got grant=%b a=%h want 100/020", grant, bram_addr); end
    @(posedge clk); #1 bram_rvalid = 1'b1; bram_rdata = 32'h9ABC_DEF0;
    @(negedge clk);
    vec++; if (rsp_valid !== 3'b100 || rsp_data !== 32'h9ABC_DEF0) begin
      miss++; $display("FAIL fixed_rsp2: got v=%b d=%h want 100/9abcdef0", rsp_valid, rsp_data); end
    @(posedge clk); #1 bram_rvalid = 1'b0;
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL fixed_release: got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    apply_reset();
    mode = 1'b1; req_we = 3'b111; req_len = '0; bram_ready = 1'b1;
    req_wdata = {32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    req_valid = 3'b111;
    for (int c = 0; c < 12; c++) begin
      exp_g = '0;
      if (c % 2 == 1) exp_g[(c / 2) % 3] = 1'b1;
      @(negedge clk);
      vec++; if (grant !== exp_g) begin
        miss++; $display("FAIL rr_grant c%0d: got %b want %b", c, grant, exp_g); end
      if (c % 2 == 1) begin
        vec++; if (bram_valid !== 1'b1 || bram_wdata !== (32'hAAAA_0000 + (c / 2) % 3)) begin
          miss++; $display("FAIL rr_wdata c%0d: got v=%b d=%h", c, bram_valid, bram_wdata); end
      end
      @(posedge clk); #1;
    end
    req_valid = '0; mode = 1'b0;
  endtask

  task automatic test_read_backpressure();
    int n_iss, n_rsp, max_out; bit tmo;
    run_read(1, 13'h0040, 4'd3, 2, 1'b1, n_iss, n_rsp, max_out, tmo);
    vec++; if (tmo) begin miss++; $display("FAIL rd_bp_timeout: got %0d rsp want 4", n_rsp); end
    vec++; if (n_iss !== 4) begin miss++; $display("FAIL rd_bp_issues: got %0d want 4", n_iss); end
    for (int k = 0; k < 4; k++) begin
      vec++; if (iss_addr[k] !== 13'h0040 + 13'(k) || rsp_dat[k] !== 32'hD000_0040 + k) begin
        miss++; $display("FAIL rd_bp_beat%0d: got a=%h d=%h", k, iss_addr[k], rsp_dat[k]); end
    end
    vec++; if (last_cnt !== 1 || rsp_last_idx !== 3) begin
      miss++; $display("FAIL rd_bp_last: got cnt=%0d idx=%0d want 1/3", last_cnt, rsp_last_idx); end
    vec++; if (owner_bad !== 0 || max_out > 4) begin
      miss++; $display("FAIL rd_bp_owner_outst: got bad=%0d max=%0d want 0/<=4", owner_bad, max_out); end
    @(negedge clk);
    vec++; if (busy !== 1'b0 || grant !== 3'b000) begin
      miss++; $display("FAIL rd_bp_release: got busy=%b grant=%b want 0/000", busy, grant); end
  endtask

  task automatic test_outstanding_limit();
    int n_iss, n_rsp, max_out; bit tmo;
    run_read(2, 13'h0300, 4'd7, 8, 1'b0, n_iss, n_rsp, max_out, tmo);
    vec++; if (tmo || n_iss !== 8) begin
      miss++; $display("FAIL outst_counts: got iss=%0d rsp=%0d want 8/8", n_iss, n_rsp); end
    vec++; if (max_out !== 4) begin miss++; $display("FAIL outst_max: got %0d want 4", max_out); end
    for (int k = 0; k < 8; k++) begin
      vec++; if (iss_addr[k] !== 13'h0300 + 13'(k)) begin
        miss++; $display("FAIL outst_addr%0d: got %h want %h", k, iss_addr[k], 13'h0300 + 13'(k)); end
    end
    vec++; if (rsp_last_idx !== 7 || owner_bad !== 0) begin
      miss++; $display("FAIL outst_last_owner: got idx=%0d bad=%0d want 7/0", rsp_last_idx, owner_bad); end
  endtask

  task automatic test_write_stall();
    logic [12:0] wa [3];
    logic [31:0] wd [3];
    int k, stall, stall_bad;
    k = 0; stall = 0; stall_bad = 0;
    bram_ready = 1'b1;
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_addr[0 +: 13] = 13'h0100; req_len[0 +: 4] = 4'd2;
    for (int cyc = 0; cyc < 50 && k < 3; cyc++) begin
      if (stall > 0) begin
        req_valid[0] = 1'b0; stall--;
        req_addr[0 +: 13] = 13'h0777; req_len[0 +: 4] = 4'hF;
      end else begin
        req_valid[0] = 1'b1; req_wdata[0 +: 32] = 32'hCAFE_0000 + k;
      end
      @(negedge clk);
      if (!req_valid[0] && bram_valid) stall_bad++;
      if (bram_valid && bram_ready && bram_we) begin
        wa[k] = bram_addr; wd[k] = bram_wdata; k++;
        if (k == 1) stall = 2;
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0; req_we[0] = 1'b0;
    vec++; if (k !== 3) begin miss++; $display("FAIL wr_count: got %0d want 3", k); end
    for (int i = 0; i < 3 && i < k; i++) begin
      vec++; if (wa[i] !== 13'h0100 + 13'(i) || wd[i] !== 32'hCAFE_0000 + i) begin
        miss++; $display("FAIL wr_beat%0d: got a=%h d=%h want %h/%h", i, wa[i], wd[i],
                         13'h0100 + 13'(i), 32'hCAFE_0000 + i); end
    end
    vec++; if (stall_bad !== 0) begin miss++; $display("FAIL wr_stall_valid: got %0d want 0", stall_bad); end
    @(negedge clk);
    vec++; if (busy !== 1'b0 || grant !== 3'b000) begin
      miss++; $display("FAIL wr_release: got busy=%b grant=%b want 0/000", busy, grant); end
  endtask

  task automatic test_addr_wrap();
    int n_iss, n_rsp, max_out; bit tmo;
    logic [12:0] exp_a [4];
    exp_a[0] = 13'h1FFE; exp_a[1] = 13'h1FFF; exp_a[2] = 13'h0000; exp_a[3] = 13'h0001;
    run_read(0, 13'h1FFE, 4'd3, 1, 1'b0, n_iss, n_rsp, max_out, tmo);
    vec++; if (tmo || n_iss !== 4) begin
      miss++; $display("FAIL wrap_counts: got iss=%0d rsp=%0d want 4/4", n_iss, n_rsp); end
    for (int k = 0; k < 4; k++) begin
      vec++; if (iss_addr[k] !== exp_a[k]) begin
        miss++; $display("FAIL wrap_addr%0d: got %h want %h", k, iss_addr[k], exp_a[k]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    bram_ready = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[13 +: 13] = 13'h0200; req_len[4 +: 4] = 4'd7;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    vec++; if (bram_valid !== 1'b1 || bram_addr !== 13'h0200) begin
      miss++; $display("FAIL rstmid_beat0: got v=%b a=%h want 1/0200", bram_valid, bram_addr); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    vec++; if (bram_addr !== 13'h0201) begin miss++; $display("FAIL rstmid_beat1: got %h want 0201", bram_addr); end
    @(posedge clk); #1 rst = 1'b0; bram_rvalid = 1'b1; bram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vec++; if (grant !== 3'b000 || busy !== 1'b0 || bram_valid !== 1'b0) begin
      miss++; $display("FAIL rstmid_state: got grant=%b busy=%b v=%b want 000/0/0", grant, busy, bram_valid); end
    vec++; if (rsp_valid !== 3'b000) begin miss++; $display("FAIL rstmid_late0: got %b want 000", rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    vec++; if (rsp_valid !== 3'b000 || rsp_last !== 1'b0) begin
      miss++; $display("FAIL rstmid_late1: got v=%b l=%b want 000/0", rsp_valid, rsp_last); end
    @(posedge clk); #1 bram_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_read_backpressure();
    test_outstanding_limit();
    test_write_stall();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
